mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction cache and the data cache. It grants one requester at a time to the shared RAM port and holds that grant for the whole RAM transaction. Data reads and writes have priority, bounded by an anti-starvation counter that forces an instruction fetch after `MAX_DSTREAK` consecutive data grants. It sits between `icache`/`dcache` and the RAM model, replacing the direct icache-to-RAM path.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 76 +++++++
 tb/tb_mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared bus, RAM handshake and arbiter state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IFETCH, DLOAD, DSTORE} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single RAM port to icache or dcache (D priority, I anti-starvation); ports: CLK/RST, icache iREN/iaddr/iwait/iload, dcache dREN/dWEN/daddr/dstore/dwait/dload, RAM ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);
  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);
  arb_state_t state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic acc;
  assign acc = ramstate_t'(ramstate) == ACCESS;
  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    case (state_q)
      IDLE: state_d = (iREN && dstreak_q == MAX_S) ? IFETCH :
                      dWEN ? DSTORE : dREN ? DLOAD : iREN ? IFETCH : IDLE;
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = !acc;
        iload   = acc ? ramload : '0;
        state_d = acc ? IDLE : IFETCH;
        dstreak_d = acc ? '0 : dstreak_q;
      end
      DLOAD, DSTORE: begin
        ramREN   = state_q == DLOAD;
        ramWEN   = state_q == DSTORE;
        ramaddr  = daddr;
        ramstore = state_q == DSTORE ? dstore : '0;
        dwait    = !acc;
        dload    = (acc && state_q == DLOAD) ? ramload : '0;
        state_d  = acc ? IDLE : state_q;
        // streak only counts D grants that an I request actually waited behind
        dstreak_d = !acc ? dstreak_q : !iREN ? '0 :
                    dstreak_q == MAX_S ? dstreak_q : dstreak_q + 4'd1;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table for reset/fetch/collision/error/reset-abort plus scoreboarded starvation run
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam logic [31:0] A_I = 32'h40, A_D = 32'h100, ST = 32'h1234, LD = 32'hDEADBEEF;
  logic CLK = 0, RST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
  logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  int checks = 0, errors = 0;

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );
  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, ir, dr, dw;
    logic [1:0] rs;
    logic ren, wen, iw, dwt;
    logic [31:0] addr, store, il, dl;
  } vec_t;
  typedef struct { logic is_i; logic [31:0] addr; } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t v(logic rst, ir, dr, dw, logic [1:0] rs, logic ren, wen, iw, dwt,
                             logic [31:0] addr, store, il, dl);
    v = '{rst, ir, dr, dw, rs, ren, wen, iw, dwt, addr, store, il, dl};
  endfunction
  function automatic vec_t idle(logic rst, ir, dr, dw, logic [1:0] rs);
    idle = v(rst, ir, dr, dw, rs, 0, 0, 1, 1, 0, 0, 0, 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    iaddr = A_I; daddr = A_D; dstore = ST; ramload = LD;
    @(posedge CLK); #1;
    // reset with requests pending, first grant is DLOAD
    vecs.push_back(idle(1, 1, 1, 0, FREE));
    vecs.push_back(idle(0, 1, 1, 0, FREE));
    vecs.push_back(v(0, 0, 1, 0, ACCESS, 1, 0, 1, 0, A_D, 0, 0, LD));
    vecs.push_back(idle(0, 0, 0, 0, FREE));
    // single fetch with 3 BUSY cycles
    vecs.push_back(idle(0, 1, 0, 0, FREE));
    for (int k = 0; k < 3; k++) vecs.push_back(v(0, 1, 0, 0, BUSY, 1, 0, 1, 1, A_I, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, ACCESS, 1, 0, 0, 1, A_I, 0, LD, 0));
    vecs.push_back(idle(0, 0, 0, 0, FREE));
    // collision: store first, one idle cycle, then fetch
    vecs.push_back(idle(0, 1, 0, 1, FREE));
    vecs.push_back(v(0, 1, 0, 1, ACCESS, 0, 1, 1, 0, A_D, ST, 0, 0));
    vecs.push_back(idle(0, 1, 0, 0, FREE));
    vecs.push_back(v(0, 1, 0, 0, ACCESS, 1, 0, 0, 1, A_I, 0, LD, 0));
    vecs.push_back(idle(0, 0, 0, 0, FREE));
    // ERROR retry during DLOAD
    vecs.push_back(idle(0, 0, 1, 0, FREE));
    for (int k = 0; k < 5; k++) vecs.push_back(v(0, 0, 1, 0, ERROR, 1, 0, 1, 1, A_D, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, ACCESS, 1, 0, 1, 0, A_D, 0, 0, LD));
    vecs.push_back(idle(0, 0, 0, 0, FREE));
    // reset in second BUSY cycle of IFETCH abandons the access
    vecs.push_back(idle(0, 1, 0, 0, FREE));
    vecs.push_back(v(0, 1, 0, 0, BUSY, 1, 0, 1, 1, A_I, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, BUSY, 1, 0, 1, 1, A_I, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0, ACCESS));
    vecs.push_back(idle(0, 0, 0, 0, FREE));
    for (int n = 0; n < vecs.size(); n++) begin
      RST = vecs[n].rst; iREN = vecs[n].ir; dREN = vecs[n].dr; dWEN = vecs[n].dw;
      ramstate = vecs[n].rs;
      @(negedge CLK);
      chk($sformatf("v%0d ramREN", n), 32'(ramREN), 32'(vecs[n].ren));
      chk($sformatf("v%0d ramWEN", n), 32'(ramWEN), 32'(vecs[n].wen));
      chk($sformatf("v%0d iwait", n), 32'(iwait), 32'(vecs[n].iw));
      chk($sformatf("v%0d dwait", n), 32'(dwait), 32'(vecs[n].dwt));
      chk($sformatf("v%0d ramaddr", n), ramaddr, vecs[n].addr);
      chk($sformatf("v%0d ramstore", n), ramstore, vecs[n].store);
      chk($sformatf("v%0d iload", n), iload, vecs[n].il);
      chk($sformatf("v%0d dload", n), dload, vecs[n].dl);
      @(posedge CLK); #1;
    end
    // starvation: I held behind continuous D reads, zero-wait RAM
    RST = 0; iREN = 1; dREN = 1; dWEN = 0; ramstate = ACCESS;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back('{1'b0, A_D});
      sb.push_back('{1'b1, A_I});
    end
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      ramload = $urandom;
      @(negedge CLK);
      if (!iwait || !dwait) begin
        exp_t e;
        e = sb.pop_front();
        chk("starve owner_is_i", 32'(!iwait), 32'(e.is_i));
        chk("starve other_wait", 32'(iwait | dwait), 32'd1);
        chk("starve ramaddr", ramaddr, e.addr);
        chk("starve load", e.is_i ? iload : dload, ramload);
      end
      @(posedge CLK); #1;
    end
    chk("starve pending_left", 32'(sb.size()), 32'd0);
    // streak cleared: with I idle a single D read is granted straight away
    iREN = 0; dREN = 1; ramstate = ACCESS; ramload = LD;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("post dwait", 32'(dwait), 32'd0);
    chk("post dload", dload, LD);
    @(posedge CLK); #1;
    dREN = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
